fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch and next-PC stage that sits directly upstream of the CPU decode/execute logic. Owns the architectural PC, issues requests to the instruction memory, holds each fetched word until the decode/execute stage accepts it, then computes the next PC: sequential, B (PC-relative), BR (register), or HLT (stop). Condition-code evaluation for branches happens here, using the flag register driven back from the ALU stage.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  16  fetch address; equals pc.
- imem_valid  in  1  instruction memory returns data this cycle.
- imem_rdata  in  16  instruction word; sampled when imem_valid=1 in WAIT.
- instr  out  16  held instruction word.
- instr_valid  out  1  instr is valid and awaiting acceptance.
- instr_ack  in  1  decode/execute consumes instr this cycle.
- flags  in  3  {Z,V,N} from ALU flag register, stable during ack cycle.
- br_reg_data  in  16  SrcData1 of BR's rs register, stable during ack cycle.
- pc  out  16  address of the held/pending instruction.
- pc_plus2  out  16  pc+2 (PCS write-back value).
- hlt  out  1  processor halted.
- icount  out  32  accepted-instruction count (see Configuration).

## Operation
- States: FETCH, WAIT, HOLD, HALTED.
- FETCH: drive imem_req=1, imem_addr=pc; go to WAIT next cycle.
- WAIT: on imem_valid, register imem_rdata into instr, go HOLD. imem_valid in any other state ignored.
- HOLD: instr_valid=1. On instr_ack: compute next PC, go FETCH (or HALTED for HLT). Without ack, stay; instr/pc unchanged.
- Next-PC, using opcode instr[15:12]:
  - 1100 B: if cond true, pc_plus2 + {{6{instr[8]}}, instr[8:0], 1'b0}; else pc_plus2.
  - 1101 BR: if cond true, {br_reg_data[15:1],1'b0}; else pc_plus2.
  - 1111 HLT: pc unchanged, enter HALTED.
  - all others: pc_plus2.
- Conditions instr[11:9]: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
- Arithmetic 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000.
- HALTED: hlt=1, instr_valid=0, no requests; left only via rst.

## Timing
- Reset values: state FETCH, pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, hlt=0, icount=0.
- First imem_req in the first cycle with rst low.
- imem_valid earliest one cycle after imem_req; arbitrary extra latency allowed.
- instr_valid rises the cycle after imem_valid; ack accepted same cycle instr_valid first high.
- Minimum 3 cycles per instruction (FETCH, WAIT, HOLD+ack).
- instr_ack while instr_valid=0 ignored.
- Branch target and next pc registered at ack edge; next imem_addr reflects it in the following FETCH cycle.
- rst in any state (incl. WAIT with response outstanding) wins: return to reset values; instruction memory shares rst and drops outstanding requests.

## Configuration
- FETCH_ICOUNT_EN defined: icount increments by 1 on every accepted instr_ack (including HLT), wraps at 2^32, cleared by rst.
- Undefined: counter not built, icount tied to 32'h0. Port list identical in both builds.

## Test plan
- Reset, memory latency 1, words 0x0123 at 0, 0x4567 at 2, ack immediately -> imem_addr 0x0000, 0x0002, 0x0004; instr_valid every 3rd cycle.
- B with ccc=001, imm=9'h004, pc=0x0010, Z=1 -> next imem_addr 0x001A; same with Z=0 -> 0x0012.
- BR ccc=111, br_reg_data=0x1235 -> next imem_addr 0x1234; B ccc=110 with V=0 -> pc+2.
- Ack withheld 5 cycles, memory latency 4 -> instr/pc stable, no extra imem_req, then single fetch after ack.
- HLT at 0x0020 acked -> hlt=1 next cycle, no further imem_req, pc=0x0020; with FETCH_ICOUNT_EN icount equals instructions acked.
- rst asserted in WAIT, imem_valid arrives during rst -> ignored; after release imem_addr=RESET_PC, instr_valid=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's memory and decode/execute signals.
// The master modport is the fetch unit. The slave modport is the
// instruction memory together with the decode/execute stage.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [2:0]  flags;
    logic [15:0] br_reg_data;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        hlt;
    logic [31:0] icount;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus2, hlt, icount,
        input  imem_valid, imem_rdata, instr_ack, flags, br_reg_data
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus2, hlt, icount,
        output imem_valid, imem_rdata, instr_ack, flags, br_reg_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage.
// It owns the PC and requests each instruction word. The word is held
// until decode/execute accepts it. The next PC is then resolved as
// sequential, B, BR or HLT.
// Optional build macro FETCH_ICOUNT_EN adds the accepted-instruction
// counter. Without it, icount is tied to zero.
//
// state   | meaning
// --------+-------------------------------------------------
// FETCH   | issue imem_req for pc
// WAIT    | request outstanding, waiting for imem_valid
// HOLD    | instr valid, waiting for instr_ack
// HALTED  | HLT accepted, idle until rst
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2;
    logic        ack_fire;
    logic        cond_true;
    logic        flag_z, flag_v, flag_n;
    logic [15:0] b_offset;

    assign pc_plus2 = pc_q + 16'd2;
    assign ack_fire = (state_q == S_HOLD) && bus.instr_ack;
    assign flag_z   = bus.flags[2];
    assign flag_v   = bus.flags[1];
    assign flag_n   = bus.flags[0];
    assign b_offset = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};

    // Branch condition decode from instr[11:9] against the ALU flags.
    always_comb begin
        cond_true = 1'b0;
        case (instr_q[11:9])
            3'b000:  cond_true = !flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z && !flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z || (!flag_z && !flag_n);
            3'b101:  cond_true = flag_n || flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // Next-state, next-PC and instruction capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.instr_ack) begin
                    state_d = S_FETCH;
                    case (instr_q[15:12])
                        OP_B:   pc_d = cond_true ? (pc_plus2 + b_offset) : pc_plus2;
                        OP_BR:  pc_d = cond_true ? (bus.br_reg_data & 16'hFFFE) : pc_plus2;
                        OP_HLT: begin
                            pc_d    = pc_q;
                            state_d = S_HALTED;
                        end
                        default: pc_d = pc_plus2;
                    endcase
                end
            end
            default: state_d = S_HALTED;
        endcase
    end

    // State, PC and held-instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [31:0] icount_q, icount_d;

    // Accepted-instruction counter. It counts the HLT ack too and wraps.
    always_comb begin
        icount_d = icount_q;
        if (ack_fire) icount_d = icount_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) icount_q <= 32'h0;
        else     icount_q <= icount_d;
    end

    assign bus.icount = icount_q;
`else
    // The counter is not built in this configuration.
    assign bus.icount = 32'h0;
`endif

    // The request is gated by rst because state already reads FETCH while
    // rst is held.
    assign bus.imem_req    = (state_q == S_FETCH) && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == S_HOLD);
    assign bus.pc          = pc_q;
    assign bus.pc_plus2    = pc_plus2;
    assign bus.hlt         = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// A table of instructions drives the memory side and the decode side.
// The table holds the hand-derived next address for each step.
// Expected fetch addresses and instruction words go through scoreboard
// queues.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_instr_q[$];
    logic [15:0] cur_addr;
    int acked = 0;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  flg;
        logic [15:0] br;
        int          lat;
        int          ackdly;
        logic [15:0] nxt;
        bit          halt;
    } step_t;

    step_t prog[15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fetch_one(input step_t s);
        int n;
        logic [15:0] exp_a;
        logic [15:0] exp_i;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
        if (exp_addr_q.size() == 0) begin
            chk("addr_sb_nonempty", 32'd0, 32'd1);
            exp_a = 16'hxxxx;
        end else begin
            exp_a = exp_addr_q.pop_front();
        end
        cur_addr = exp_a;
        chk("imem_addr", {16'd0, bus.imem_addr}, {16'd0, exp_a});
        chk("valid_low_fetch", {31'd0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        // A stray ack while no instruction is held must be ignored.
        bus.instr_ack = 1'b1;
        repeat (s.lat - 1) begin
            chk("no_req_wait", {31'd0, bus.imem_req}, 32'd0);
            @(negedge clk);
        end
        bus.instr_ack  = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = s.word;
        exp_instr_q.push_back(s.word);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'($urandom);
        chk("instr_valid", {31'd0, bus.instr_valid}, 32'd1);
        if (exp_instr_q.size() == 0) begin
            chk("instr_sb_nonempty", 32'd0, 32'd1);
            exp_i = 16'hxxxx;
        end else begin
            exp_i = exp_instr_q.pop_front();
        end
        chk("instr", {16'd0, bus.instr}, {16'd0, exp_i});
        chk("pc", {16'd0, bus.pc}, {16'd0, cur_addr});
        chk("pc_plus2", {16'd0, bus.pc_plus2}, {16'd0, 16'(cur_addr + 16'd2)});
        repeat (s.ackdly) begin
            // Responses outside WAIT must not disturb the held word.
            bus.imem_valid = 1'b1;
            bus.imem_rdata = 16'hBEEF;
            @(negedge clk);
            bus.imem_valid = 1'b0;
            chk("hold_no_req", {31'd0, bus.imem_req}, 32'd0);
            chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("hold_instr", {16'd0, bus.instr}, {16'd0, s.word});
            chk("hold_pc", {16'd0, bus.pc}, {16'd0, cur_addr});
        end
        bus.instr_ack   = 1'b1;
        bus.flags       = s.flg;
        bus.br_reg_data = s.br;
        acked++;
        if (!s.halt) exp_addr_q.push_back(s.nxt);
        @(negedge clk);
        bus.instr_ack   = 1'b0;
        bus.flags       = 3'b000;
        bus.br_reg_data = 16'h0000;
    endtask

    initial begin
        bus.imem_valid  = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.instr_ack   = 1'b0;
        bus.flags       = 3'b000;
        bus.br_reg_data = 16'h0000;

        //            word      flg     br        lat ack nxt       halt
        prog[0]  = '{16'h0123, 3'b000, 16'h0000, 1, 0, 16'h0002, 1'b0};
        prog[1]  = '{16'h4567, 3'b000, 16'h0000, 1, 0, 16'h0004, 1'b0};
        prog[2]  = '{16'hDE00, 3'b000, 16'hFFFF, 1, 0, 16'hFFFE, 1'b0};
        prog[3]  = '{16'h0000, 3'b000, 16'h0000, 2, 0, 16'h0000, 1'b0};
        prog[4]  = '{16'hDE00, 3'b000, 16'h1235, 1, 0, 16'h1234, 1'b0};
        prog[5]  = '{16'hD000, 3'b000, 16'h0010, 1, 0, 16'h0010, 1'b0};
        prog[6]  = '{16'hC204, 3'b100, 16'h0000, 1, 0, 16'h001A, 1'b0};
        prog[7]  = '{16'hC204, 3'b000, 16'h0000, 1, 0, 16'h001C, 1'b0};
        prog[8]  = '{16'hCDF0, 3'b000, 16'h0000, 1, 0, 16'h001E, 1'b0};
        prog[9]  = '{16'h1234, 3'b000, 16'h0000, 4, 5, 16'h0020, 1'b0};
        prog[10] = '{16'hCDF3, 3'b010, 16'h0000, 1, 0, 16'h0008, 1'b0};
        prog[11] = '{16'hC40B, 3'b000, 16'h0000, 1, 0, 16'h0020, 1'b0};
        prog[12] = '{16'hD600, 3'b000, 16'h4444, 3, 0, 16'h0022, 1'b0};
        prog[13] = '{16'hCBFE, 3'b100, 16'h0000, 1, 0, 16'h0020, 1'b0};
        prog[14] = '{16'hF000, 3'b000, 16'h0000, 1, 0, 16'h0020, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_hlt", {31'd0, bus.hlt}, 32'd0);
        chk("rst_pc", {16'd0, bus.pc}, 32'h0000);
        chk("rst_instr", {16'd0, bus.instr}, 32'h0000);
        chk("rst_icount", bus.icount, 32'd0);

        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        exp_addr_q.push_back(16'h0000);
        for (int i = 0; i < 15; i++) fetch_one(prog[i]);

        chk("halt_hlt", {31'd0, bus.hlt}, 32'd1);
        chk("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("halt_pc", {16'd0, bus.pc}, 32'h0020);
`ifdef FETCH_ICOUNT_EN
        chk("icount", bus.icount, acked);
`else
        chk("icount", bus.icount, 32'd0);
`endif
        bus.instr_ack = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("halt_no_req", {31'd0, bus.imem_req}, 32'd0);
            chk("halt_stay", {31'd0, bus.hlt}, 32'd1);
        end
        bus.instr_ack = 1'b0;

        // Reset from HALTED, then reset again while a request is outstanding.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rearm_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rearm_addr", {16'd0, bus.imem_addr}, 32'h0000);
        @(negedge clk);
        rst = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 16'h5555;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        chk("rstwait_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rstwait_instr", {16'd0, bus.instr}, 32'h0000);
        chk("rstwait_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("post_rst_addr", {16'd0, bus.imem_addr}, 32'h0000);
        chk("post_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("post_rst_hlt", {31'd0, bus.hlt}, 32'd0);
        chk("post_rst_icount", bus.icount, 32'd0);
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_addr_q.push_back(16'h0000);
        fetch_one('{16'h0777, 3'b000, 16'h0000, 1, 0, 16'h0002, 1'b0});
        fetch_one('{16'h0888, 3'b000, 16'h0000, 1, 0, 16'h0004, 1'b0});
        chk("final_addr", {16'd0, bus.imem_addr}, 32'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
